line_window_spad: RTL and testbench
===================================

// Module: line_window_spad
// PURPOSE
//  Parametrised row-window scratchpad feeding the conv PE array. Stores up to KMAX feature rows
//  written as packed bus words and returns one K-row column vector per read.
//  Replaces per-line FIFOs plus shift-back buffers with a rotating row-slot ring.
//  A row is written once and reused for K vertical window positions without re-fetch or copy.
//  Kernel height K is runtime-selectable in 1..KMAX; row length is runtime-selectable.
// PARAMETERS
//  FEATURE_WIDTH   16   bits per feature
//  DATA_BUS_WIDTH  128  write bus width; PACK = DATA_BUS_WIDTH/FEATURE_WIDTH features/word (power of 2)
//  KMAX            5    row slots = max kernel height
//  ROW_WORDS_MAX   32   max bus words per row; slot RAM = ROW_WORDS_MAX x DATA_BUS_WIDTH
//  CW = $clog2(ROW_WORDS_MAX*PACK), KW = $clog2(KMAX+1), RW = $clog2(ROW_WORDS_MAX+1)
// PORTS
//  clk            in   1                   clock
//  rst            in   1                   async reset, active-high
//  cfg_load       in   1                   pulse: latch cfg_k/cfg_row_words, clear window state
//  cfg_k          in   KW                  kernel height K
//  cfg_row_words  in   RW                  bus words per row
//  cfg_err        out  1                   1-cycle pulse: rejected config
//  wr_valid       in   1                   write word valid
//  wr_ready       out  1                   slot free for writing
//  wr_data        in   DATA_BUS_WIDTH      packed features; feature 0 in [FEATURE_WIDTH-1:0]
//  rd_req         in   1                   request next column
//  rd_valid       out  1                   rd_data valid
//  rd_data        out  KMAX*FEATURE_WIDTH  lane j = row (base+j) mod KMAX; lanes j>=K forced 0
//  rd_last        out  1                   with rd_valid: last column of row
//  rows_full      out  KW                  completely written rows held
// BEHAVIOUR
//  Reset: state IDLE; wr_ready=0; rd_valid=0; rd_last=0; cfg_err=0; rows_full=0;
//   base=0; wr_word=0; rd_col=0; rd_data=0. RAM contents undefined.
//  FSM IDLE->RUN on cfg_load with 1<=cfg_k<=KMAX and 1<=cfg_row_words<=ROW_WORDS_MAX.
//  Illegal config: cfg_err pulses next cycle; FSM goes or stays IDLE.
//  cfg_load in RUN: config is re-checked. All counters, base and rows_full clear in every case.
//   Any in-flight rd_valid is dropped.
//  Write (RUN): wr_ready = (rows_full < KMAX).
//   On wr_valid&wr_ready, word goes to slot (base+rows_full) mod KMAX at address wr_word; wr_word++.
//   At wr_word==row_words-1: wr_word wraps to 0 and the row counts as full (rows_full+1).
//  Read (RUN): column issued when rd_req & rows_full>=K.
//   Read returns word rd_col/PACK, feature rd_col%PACK from each active slot.
//   rd_data and rd_valid are registered: latency exactly 1 cycle. rd_req with rows_full<K is ignored.
//  rd_col++ per issue. On the issue of rd_col == row_words*PACK-1:
//   rd_last=1 on the corresponding output; rd_col->0; base->(base+1) mod KMAX; rows_full-1.
//  Simultaneous write-row-complete and read-row-complete in one cycle: rows_full unchanged.
//   base still advances; write slot index uses pre-advance base+rows_full.
//  Write to a slot while a read of the same slot is in progress cannot occur.
//   A slot is writable only after its rows_full entry is released.
//  Mod-KMAX arithmetic uses compare-and-subtract, never '%'. KMAX need not be a power of 2.
//  Reset mid-row: partial write/read progress is discarded; bench must reconfigure.
// TESTING
//  1. Reset, then cfg K=3, row_words=2 -> RUN, wr_ready=1, rows_full=0, no cfg_err.
//  2. Write 6 words, rows r0..r2 with feature = row*16+col -> rows_full=3.
//     32 rd_req -> lane0..2 = {c, 16+c, 32+c}, lanes 3..4 = 0.
//     rd_last on col 15; base=1; rows_full=2.
//  3. K=5, row_words=1: write 5 rows -> wr_ready=0. A 6th wr_valid is not accepted.
//     After one full row read -> wr_ready=1.
//  4. K=3, 3 rows held, 4th row's last word written in the same cycle as rd_last issue ->
//     rows_full stays 3, base=1. Next read returns rows 1,2,3.
//  5. Run 8 row windows with K=5 to wrap base past KMAX-1 -> lane order stays consecutive rows.
//  6. cfg_k=0, then cfg_k=6, then row_words=0 -> cfg_err pulse each time, stays IDLE.
//     Async rst mid-read -> all outputs at reset values the same cycle.

Source files
------------

// File: rtl/line_window_spad.sv
// Rotating K-row scratchpad: rows land in ring slots once and are read back as K-lane columns.
// Read data is registered one cycle after rd_req; writes stall via wr_ready while every slot holds a full row.
module line_window_spad #(
   parameter int FEATURE_WIDTH  = 16,
   parameter int DATA_BUS_WIDTH = 128,
   parameter int KMAX           = 5,
   parameter int ROW_WORDS_MAX  = 32,
   localparam int PACK = DATA_BUS_WIDTH / FEATURE_WIDTH,
   localparam int CW   = $clog2(ROW_WORDS_MAX * PACK),
   localparam int KW   = $clog2(KMAX + 1),
   localparam int RW   = $clog2(ROW_WORDS_MAX + 1)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cfg_load,
   input  logic [KW-1:0]                 cfg_k,
   input  logic [RW-1:0]                 cfg_row_words,
   output logic                          cfg_err,
   input  logic                          wr_valid,
   output logic                          wr_ready,
   input  logic [DATA_BUS_WIDTH-1:0]     wr_data,
   input  logic                          rd_req,
   output logic                          rd_valid,
   output logic [KMAX*FEATURE_WIDTH-1:0] rd_data,
   output logic                          rd_last,
   output logic [KW-1:0]                 rows_full
);

   localparam int PW = $clog2(PACK);
   localparam int AW = $clog2(ROW_WORDS_MAX);

   typedef logic [PACK-1:0][FEATURE_WIDTH-1:0] word_t;
   typedef enum logic {S_IDLE, S_RUN} state_t;

   word_t mem [0:KMAX-1][0:ROW_WORDS_MAX-1];

   state_t        state_q, state_d;
   logic [KW-1:0] k_q, k_d, base_q, base_d, rows_full_q, rows_full_d;
   logic [RW-1:0] row_words_q, row_words_d;
   logic [AW-1:0] wr_word_q, wr_word_d;
   logic [CW-1:0] rd_col_q, rd_col_d;
   logic          rd_valid_q, rd_valid_d, rd_last_q, rd_last_d, cfg_err_q, cfg_err_d;
   logic [KMAX-1:0][FEATURE_WIDTH-1:0] rd_data_q, rd_data_d, lanes;

   logic          running, cfg_ok, wr_acc, rd_issue, wr_row_done, rd_row_done;
   logic [KW:0]   wr_slot_sum, lane_slot;
   logic [KW-1:0] wr_slot;
   logic [CW:0]   col_end;
   logic [CW-1:0] col_last;

   assign running     = (state_q == S_RUN);
   assign cfg_ok      = (cfg_k != '0) && (cfg_k <= KW'(KMAX)) &&
                        (cfg_row_words != '0) && (cfg_row_words <= RW'(ROW_WORDS_MAX));
   assign wr_ready    = running && (rows_full_q < KW'(KMAX));
   assign wr_acc      = wr_ready && wr_valid && !cfg_load;
   assign rd_issue    = running && rd_req && !cfg_load && (rows_full_q >= k_q);
   assign col_end     = (CW+1)'(row_words_q) << PW;
   assign col_last    = CW'(col_end - (CW+1)'(1));
   assign wr_row_done = wr_acc && (RW'(wr_word_q) == row_words_q - RW'(1));
   assign rd_row_done = rd_issue && (rd_col_q == col_last);

   // Newest free slot sits rows_full positions past the oldest held row.
   assign wr_slot_sum = (KW+1)'(base_q) + (KW+1)'(rows_full_q);
   assign wr_slot     = (wr_slot_sum >= (KW+1)'(KMAX)) ? KW'(wr_slot_sum - (KW+1)'(KMAX))
                                                       : KW'(wr_slot_sum);

   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_slot][wr_word_q] <= wr_data;
   end

   always_comb begin
      lanes     = '0;
      lane_slot = '0;
      for (int j = 0; j < KMAX; j++) begin
         lane_slot = (KW+1)'(base_q) + (KW+1)'(j);
         if (lane_slot >= (KW+1)'(KMAX)) lane_slot = lane_slot - (KW+1)'(KMAX);
         if (KW'(j) < k_q) lanes[j] = mem[KW'(lane_slot)][rd_col_q[CW-1:PW]][rd_col_q[PW-1:0]];
      end
   end

   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      row_words_d = row_words_q;
      base_d      = base_q;
      rows_full_d = rows_full_q;
      wr_word_d   = wr_word_q;
      rd_col_d    = rd_col_q;
      rd_valid_d  = 1'b0;
      rd_last_d   = 1'b0;
      rd_data_d   = rd_data_q;
      cfg_err_d   = 1'b0;
      if (cfg_load) begin
         k_d         = cfg_k;
         row_words_d = cfg_row_words;
         base_d      = '0;
         rows_full_d = '0;
         wr_word_d   = '0;
         rd_col_d    = '0;
         state_d     = cfg_ok ? S_RUN : S_IDLE;
         cfg_err_d   = !cfg_ok;
      end else if (running) begin
         if (wr_acc) wr_word_d = wr_row_done ? '0 : wr_word_q + AW'(1);
         if (rd_issue) begin
            rd_valid_d = 1'b1;
            rd_data_d  = lanes;
            if (rd_row_done) begin
               rd_col_d  = '0;
               rd_last_d = 1'b1;
               base_d    = (base_q == KW'(KMAX - 1)) ? '0 : base_q + KW'(1);
            end else begin
               rd_col_d  = rd_col_q + CW'(1);
            end
         end
         if (wr_row_done && !rd_row_done)      rows_full_d = rows_full_q + KW'(1);
         else if (!wr_row_done && rd_row_done) rows_full_d = rows_full_q - KW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         k_q         <= '0;
         row_words_q <= '0;
         base_q      <= '0;
         rows_full_q <= '0;
         wr_word_q   <= '0;
         rd_col_q    <= '0;
         rd_valid_q  <= 1'b0;
         rd_last_q   <= 1'b0;
         rd_data_q   <= '0;
         cfg_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         row_words_q <= row_words_d;
         base_q      <= base_d;
         rows_full_q <= rows_full_d;
         wr_word_q   <= wr_word_d;
         rd_col_q    <= rd_col_d;
         rd_valid_q  <= rd_valid_d;
         rd_last_q   <= rd_last_d;
         rd_data_q   <= rd_data_d;
         cfg_err_q   <= cfg_err_d;
      end
   end

   assign cfg_err   = cfg_err_q;
   assign rd_valid  = rd_valid_q;
   assign rd_last   = rd_last_q;
   assign rd_data   = rd_data_q;
   assign rows_full = rows_full_q;

endmodule

// File: tb/tb_line_window_spad.sv
// Bench for line_window_spad: a queue of completed rows models the window; columns come from its head K rows.
module tb_line_window_spad;
   localparam int FW = 16, DBW = 128, KMAX = 5, RWMAX = 32, PACK = 8, KW = 3, RW = 6;

   logic              clk = 1'b0, rst = 1'b1, cfg_load = 1'b0;
   logic [KW-1:0]     cfg_k = '0;
   logic [RW-1:0]     cfg_row_words = '0;
   logic              cfg_err, wr_ready, rd_valid, rd_last;
   logic              wr_valid = 1'b0, rd_req = 1'b0;
   logic [DBW-1:0]    wr_data = '0;
   logic [KMAX*FW-1:0] rd_data;
   logic [KW-1:0]     rows_full;

   always #5 clk = ~clk;

   line_window_spad dut (
      .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_k(cfg_k), .cfg_row_words(cfg_row_words),
      .cfg_err(cfg_err), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
      .rows_full(rows_full)
   );

   int n_checks = 0, n_fail = 0;

   typedef logic [FW-1:0] row_t [RWMAX*PACK];
   row_t fullq[$];
   row_t cur_row;
   int   m_wword, m_col, m_k, m_rw;
   bit   m_run;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DBW-1:0] rnd_word();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [DBW-1:0] pat_word(input int r, input int w);
      logic [DBW-1:0] v;
      v = '0;
      for (int f = 0; f < PACK; f++) v[f*FW +: FW] = FW'(r*16 + w*PACK + f);
      return v;
   endfunction

   task automatic do_cfg(input int k, input int rw);
      bit ok;
      ok = (k >= 1) && (k <= KMAX) && (rw >= 1) && (rw <= RWMAX);
      cfg_load = 1'b1; cfg_k = KW'(k); cfg_row_words = RW'(rw);
      wr_valid = 1'b0; rd_req = 1'b0;
      @(posedge clk); #1;
      cfg_load = 1'b0;
      m_run = ok; m_k = k; m_rw = rw; m_wword = 0; m_col = 0;
      fullq.delete();
      chk("cfg_err", cfg_err, !ok);
      chk("cfg_rows_full", rows_full, 0);
      chk("cfg_rd_valid", rd_valid, 0);
      chk("cfg_wr_ready", wr_ready, ok);
      @(posedge clk); #1;
      chk("cfg_err_pulse", cfg_err, 0);
   endtask

   task automatic cycle(input bit wv, input logic [DBW-1:0] wd, input bit rr);
      bit acc, issue, last;
      logic [KMAX*FW-1:0] exp;
      wr_valid = wv; wr_data = wd; rd_req = rr;
      chk("wr_ready", wr_ready, m_run && (fullq.size() < KMAX));
      acc   = wv && m_run && (fullq.size() < KMAX);
      issue = rr && m_run && (fullq.size() >= m_k);
      exp   = '0;
      last  = 1'b0;
      if (issue) begin
         for (int j = 0; j < m_k; j++) exp[j*FW +: FW] = fullq[j][m_col];
         last = (m_col == m_rw*PACK - 1);
      end
      @(posedge clk); #1;
      wr_valid = 1'b0; rd_req = 1'b0;
      if (acc) begin
         for (int f = 0; f < PACK; f++) cur_row[m_wword*PACK + f] = wd[f*FW +: FW];
         m_wword++;
         if (m_wword == m_rw) begin
            fullq.push_back(cur_row);
            m_wword = 0;
         end
      end
      if (issue) begin
         if (last) begin
            fullq.delete(0);
            m_col = 0;
         end else m_col++;
      end
      chk("rd_valid", rd_valid, issue);
      if (issue) chk("rd_data", rd_data, exp);
      chk("rd_last", rd_last, last);
      chk("rows_full", rows_full, fullq.size());
   endtask

   initial begin
      logic [KMAX*FW-1:0] spot;
      int ks [4] = '{5, 2, 4, 1};
      int rws[4] = '{2, 3, 1, 4};
      m_run = 0; m_k = 1; m_rw = 1; m_wword = 0; m_col = 0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_last", rd_last, 0);
      chk("rst_cfg_err", cfg_err, 0);
      chk("rst_rows_full", rows_full, 0);
      chk("rst_rd_data", rd_data, 0);
      rst = 1'b0;

      // Patterned rows: feature = row*16 + column
      do_cfg(3, 2);
      for (int r = 0; r < 3; r++)
         for (int w = 0; w < 2; w++) cycle(1'b1, pat_word(r, w), 1'b0);
      chk("t2_rows_full", rows_full, 3);
      spot = {16'd0, 16'd0, 16'd32, 16'd16, 16'd0};
      for (int i = 0; i < 32; i++) begin
         cycle(1'b0, '0, 1'b1);
         if (i == 0) chk("t2_col0", rd_data, spot);
      end

      // All slots full stalls the writer until a row is consumed
      do_cfg(5, 1);
      for (int r = 0; r < 6; r++) cycle(1'b1, rnd_word(), 1'b0);
      chk("t3_full_ready", wr_ready, 0);
      for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1);
      chk("t3_ready_after", wr_ready, 1);

      // Row completes on the write side as the oldest row retires
      do_cfg(3, 1);
      for (int r = 0; r < 3; r++) cycle(1'b1, rnd_word(), 1'b0);
      for (int i = 0; i < 7; i++) cycle(1'b0, '0, 1'b1);
      cycle(1'b1, rnd_word(), 1'b1);
      chk("t4_rows_full", rows_full, 3);
      for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1);

      for (int c = 0; c < 4; c++) begin
         do_cfg(ks[c], rws[c]);
         repeat (300) cycle($urandom_range(0, 99) < 60, rnd_word(), $urandom_range(0, 99) < 75);
      end

      do_cfg(0, 2);
      do_cfg(6, 2);
      do_cfg(3, 0);
      cycle(1'b1, rnd_word(), 1'b1);

      // Asynchronous reset while a column is being returned
      do_cfg(3, 1);
      for (int r = 0; r < 3; r++) cycle(1'b1, rnd_word(), 1'b0);
      cycle(1'b0, '0, 1'b1);
      rst = 1'b1;
      #1;
      chk("arst_rd_valid", rd_valid, 0);
      chk("arst_rd_data", rd_data, 0);
      chk("arst_rows_full", rows_full, 0);
      chk("arst_wr_ready", wr_ready, 0);
      chk("arst_rd_last", rd_last, 0);
      chk("arst_cfg_err", cfg_err, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      m_run = 0; fullq.delete(); m_wword = 0; m_col = 0;
      do_cfg(2, 1);
      for (int r = 0; r < 2; r++) cycle(1'b1, rnd_word(), 1'b0);
      for (int i = 0; i < 9; i++) cycle(1'b0, '0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
